// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_cpu_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);
  localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  // Magnitude of x when en is set (signed op), otherwise x unchanged.
  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] x, input logic en);
    return (en && x[XLEN-1]) ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mips_cpu_muldiv_step
  import mips_cpu_muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc_in,
  input  logic [31:0] opnd,
  output logic [63:0] acc_out
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] diff;

  always_comb begin
    sum    = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, opnd} : 33'd0);
    rem_sh = acc_in[63:31];
    ge     = rem_sh >= {1'b0, opnd};
    diff   = 32'(rem_sh - {1'b0, opnd});
    if (is_div) begin
      // Quotient bit enters at the bottom as the dividend shifts out of the top.
      acc_out = ge ? {diff, acc_in[30:0], 1'b1} : {rem_sh[31:0], acc_in[30:0], 1'b0};
    end else begin
      acc_out = {sum, acc_in[31:1]};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div_q;
  logic               neg_q;
  logic               neg_r;
  logic               div0;
  logic [31:0]        a_q;
  logic [31:0]        opnd;
  logic [63:0]        acc;
  logic [63:0]        acc_nxt;
  logic [63:0]        prod;
  logic [31:0]        fix_hi;
  logic [31:0]        fix_lo;
  logic               sgn_in;

  assign sgn_in = ~op[0];

  mips_cpu_muldiv_step u_step (
    .is_div  (is_div_q),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (acc_nxt)
  );

  // Final sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    prod   = neg_q ? 64'(-acc) : acc;
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
    if (is_div_q) begin
      if (div0) begin
        fix_hi = a_q;
        fix_lo = DIV0_LO;
      end else begin
        fix_hi = neg_r ? 32'(-acc[63:32]) : acc[63:32];
        fix_lo = neg_q ? 32'(-acc[31:0]) : acc[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      a_q      <= '0;
      opnd     <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Multiply keeps |b| in the accumulator; divide keeps |a| there.
            is_div_q <= op[1];
            neg_q    <= sgn_in & (a[31] ^ b[31]);
            neg_r    <= sgn_in & a[31];
            div0     <= (b == 32'd0);
            a_q      <= a;
            acc      <= {32'd0, op[1] ? abs_if(a, sgn_in) : abs_if(b, sgn_in)};
            opnd     <= op[1] ? abs_if(b, sgn_in) : abs_if(a, sgn_in);
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= S_CALC;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Randomized and directed self-checking bench for the multiply/divide unit.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  mips_cpu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Architectural result of one operation, straight from the ISA definition.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mh, output logic [31:0] ml);
    longint sx, sy, p;
    logic [63:0] u;
    int ix, iy;
    mh = '0;
    ml = '0;
    case (o)
      2'd0: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
        u  = 64'(p);
        mh = u[63:32];
        ml = u[31:0];
      end
      2'd1: begin
        u  = {32'd0, x} * {32'd0, y};
        mh = u[63:32];
        ml = u[31:0];
      end
      2'd2: begin
        if (y == 32'd0) begin
          mh = x;
          ml = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          mh = 32'd0;
          ml = 32'h8000_0000;
        end else begin
          ix = x;
          iy = y;
          ml = 32'(ix / iy);
          mh = 32'(ix % iy);
        end
      end
      default: begin
        if (y == 32'd0) begin
          mh = x;
          ml = 32'hFFFF_FFFF;
        end else begin
          ml = x / y;
          mh = x % y;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it until done (bounded); inputs are scrambled after acceptance.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int busy_n, output int done_at);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    busy_n  = 0;
    done_at = -1;
    for (int e = 0; e <= 40; e++) begin
      if (done) begin
        done_at = e;
        break;
      end
      if (busy) busy_n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    int bn, da;
    v[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[3] = '{2'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
    v[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    v[5] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    v[6] = '{2'd3, 32'd7,         32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0000};
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].o, v[i].x, v[i].y, bn, da);
      n_cmp++; if (bn !== 33) begin n_bad++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bn); end
      n_cmp++; if (da !== 33) begin n_bad++; $display("FAIL dir%0d_latency got=%0d exp=33", i, da); end
      n_cmp++; if (hi !== v[i].eh) begin n_bad++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, v[i].eh); end
      n_cmp++; if (lo !== v[i].el) begin n_bad++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, v[i].el); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, busy); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse_width got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y, eh, el;
    int bn, da, sel;
    for (int i = 0; i < 24; i++) begin
      o   = 2'($urandom_range(0, 3));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = 32'd0;
      else if (sel == 1) y = 32'($urandom_range(1, 15));
      else if (sel == 2) x = 32'($urandom_range(0, 300));
      model(o, x, y, eh, el);
      do_op(o, x, y, bn, da);
      n_cmp++; if (da !== 33) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d exp=33", i, da); end
      n_cmp++; if (hi !== eh) begin n_bad++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, hi, eh); end
      n_cmp++; if (lo !== el) begin n_bad++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, lo, el); end
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] oh, ol, eh, el;
    int got;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    oh = 32'hA5A5_0F0F; ol = 32'hA5A5_0F0F;
    model(2'd1, 32'd6, 32'd7, eh, el);
    op = 2'd1; a = 32'd6; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    got = -1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 5) begin
        start = 1'b1; op = 2'd3; a = 32'd1; b = 32'd1; mthi = 1'b1; wdata = 32'h0000_DEAD;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      tick();
      if (e == 10) begin
        n_cmp++; if (hi !== oh) begin n_bad++; $display("FAIL busy_hi_hold got=%h exp=%h", hi, oh); end
        n_cmp++; if (lo !== ol) begin n_bad++; $display("FAIL busy_lo_hold got=%h exp=%h", lo, ol); end
      end
      if (done) begin
        got = e;
        break;
      end
    end
    start = 1'b0; mthi = 1'b0;
    n_cmp++; if (got !== 33) begin n_bad++; $display("FAIL busy_ignore_latency got=%0d exp=33", got); end
    n_cmp++; if (hi !== eh) begin n_bad++; $display("FAIL busy_ignore_hi got=%h exp=%h", hi, eh); end
    n_cmp++; if (lo !== el) begin n_bad++; $display("FAIL busy_ignore_lo got=%h exp=%h", lo, el); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_CAFE;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    op = 2'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b exp=0", done); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL midrst_hi got=%h exp=0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL midrst_lo got=%h exp=0", lo); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_stale_activity got=%0d exp=0", seen); end
  endtask

  task automatic test_mt();
    int got;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    n_cmp++; if (hi !== 32'h1234_5678) begin n_bad++; $display("FAIL mt_both_hi got=%h exp=12345678", hi); end
    n_cmp++; if (lo !== 32'h1234_5678) begin n_bad++; $display("FAIL mt_both_lo got=%h exp=12345678", lo); end
    mthi = 1'b1; wdata = 32'h1111_1111;
    tick();
    mthi = 1'b0;
    n_cmp++; if (hi !== 32'h1111_1111) begin n_bad++; $display("FAIL mthi_only_hi got=%h exp=11111111", hi); end
    n_cmp++; if (lo !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi_only_lo got=%h exp=12345678", lo); end
    op = 2'd1; a = 32'd2; b = 32'd3; start = 1'b1; mtlo = 1'b1; wdata = 32'h9999_9999;
    tick();
    start = 1'b0; mtlo = 1'b0;
    n_cmp++; if (lo !== 32'h1234_5678) begin n_bad++; $display("FAIL mt_with_start_lo got=%h exp=12345678", lo); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mt_start_busy got=%b exp=1", busy); end
    mthi = 1'b1; wdata = 32'h5555_5555;
    tick();
    mthi = 1'b0;
    n_cmp++; if (hi !== 32'h1111_1111) begin n_bad++; $display("FAIL mt_while_busy_hi got=%h exp=11111111", hi); end
    got = -1;
    for (int e = 2; e <= 40; e++) begin
      tick();
      if (done) begin
        got = e;
        break;
      end
    end
    n_cmp++; if (got !== 33) begin n_bad++; $display("FAIL mt_mul_latency got=%0d exp=33", got); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL mt_mul_hi got=%h exp=0", hi); end
    n_cmp++; if (lo !== 32'd6) begin n_bad++; $display("FAIL mt_mul_lo got=%h exp=6", lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, x2, y2, eh, el;
    int bn, da;
    x1 = $urandom; y1 = $urandom;
    x2 = $urandom; y2 = 32'($urandom_range(1, 1000));
    model(2'd0, x1, y1, eh, el);
    do_op(2'd0, x1, y1, bn, da);
    n_cmp++; if (hi !== eh || lo !== el) begin
      n_bad++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", hi, lo, eh, el);
    end
    model(2'd2, x2, y2, eh, el);
    do_op(2'd2, x2, y2, bn, da);
    n_cmp++; if (bn !== 33) begin n_bad++; $display("FAIL b2b_second_busy got=%0d exp=33", bn); end
    n_cmp++; if (da !== 33) begin n_bad++; $display("FAIL b2b_second_latency got=%0d exp=33", da); end
    n_cmp++; if (hi !== eh || lo !== el) begin
      n_bad++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", hi, lo, eh, el);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_mt();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
